// File: rtl/ahb_arb_pkg.sv
// Shared encodings and helpers for the five-master AHB arbiter.
// Burst length decode and grant-to-index conversion live here so the top stays small.
package ahb_arb_pkg;

    localparam int NMST  = 5;
    localparam int IDX_W = $clog2(NMST);
    localparam int REM_W = 5;
    localparam int GNT_W = 16;

    localparam logic [1:0] HTRANS_IDLE   = 2'd0;
    localparam logic [1:0] HTRANS_BUSY   = 2'd1;
    localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
    localparam logic [1:0] HTRANS_SEQ    = 2'd3;

    localparam logic [2:0] HBURST_SINGLE = 3'd0;
    localparam logic [2:0] HBURST_INCR   = 3'd1;
    localparam logic [2:0] HBURST_WRAP4  = 3'd2;
    localparam logic [2:0] HBURST_INCR4  = 3'd3;
    localparam logic [2:0] HBURST_WRAP8  = 3'd4;
    localparam logic [2:0] HBURST_INCR8  = 3'd5;
    localparam logic [2:0] HBURST_WRAP16 = 3'd6;
    localparam logic [2:0] HBURST_INCR16 = 3'd7;

    typedef enum logic [1:0] {
        ARB_OPEN  = 2'd0,
        ARB_BURST = 2'd1,
        ARB_LOCK  = 2'd2
    } arb_state_e;

    // Beats remaining after the NONSEQ beat; undefined-length INCR counts as single.
    function automatic logic [REM_W-1:0] burst_beats(input logic [2:0] hburst);
        logic [REM_W-1:0] beats;
        beats = '0;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  beats = 5'd3;
            HBURST_WRAP8,  HBURST_INCR8:  beats = 5'd7;
            HBURST_WRAP16, HBURST_INCR16: beats = 5'd15;
            default:                      beats = 5'd0;
        endcase
        return beats;
    endfunction

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NMST-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NMST; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/ahb_arb_pick.sv
// Combinational priority scanner: first valid one-hot prio field with a matching
// request wins; malformed fields are skipped and no winner falls back to DEF_MST.
module ahb_arb_pick #(
    parameter int NMST    = 5,
    parameter int DEF_MST = 0
) (
    input  logic [NMST*NMST-1:0] prio,
    input  logic [NMST-1:0]      hbusreq,
    output logic [NMST-1:0]      winner
);

    logic [NMST-1:0] hit;

    for (genvar k = 0; k < NMST; k++) begin : g_fld
        logic [NMST-1:0] fld;
        assign fld    = prio[k*NMST +: NMST];
        assign hit[k] = (fld != '0) && ((fld & (fld - 1'b1)) == '0) &&
                        ((fld & hbusreq) != '0);
    end

    // Scan from the lowest-priority field upward so field 0 has the final say.
    always_comb begin
        winner = NMST'(1) << DEF_MST;
        for (int k = NMST - 1; k >= 0; k--) begin
            if (hit[k]) winner = prio[k*NMST +: NMST];
        end
    end

endmodule

// File: rtl/ahb_arbiter.sv
// Five-master AHB arbiter: registered one-hot grant frozen during fixed bursts and
// locked sequences, plus data-phase owner tracking for the slave-side muxes.
module ahb_arbiter #(
    parameter int NMST    = 5,
    parameter int DEF_MST = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NMST-1:0]      hbusreq,
    input  logic [NMST-1:0]      hlock,
    input  logic [1:0]           htrans,
    input  logic [2:0]           hburst,
    input  logic                 hready,
    input  logic [NMST*NMST-1:0] prio,
    output logic [15:0]          hgrantx,
    output logic [3:0]           hmaster,
    output logic                 hmastlock
);

    import ahb_arb_pkg::*;

    logic [REM_W-1:0] rem;
    logic [REM_W-1:0] rem_next;
    logic [NMST-1:0]  pick_oh;
    logic [NMST-1:0]  grant_q;
    logic [IDX_W-1:0] grant_sel;
    arb_state_e       state;

    ahb_arb_pick #(
        .NMST    (NMST),
        .DEF_MST (DEF_MST)
    ) u_pick (
        .prio    (prio),
        .hbusreq (hbusreq),
        .winner  (pick_oh)
    );

    assign grant_sel = onehot_to_idx(grant_q);
    assign hgrantx   = {{(GNT_W-NMST){1'b0}}, grant_q};

    always_comb begin
        rem_next = rem;
        if (hready) begin
            case (htrans)
                HTRANS_NONSEQ: rem_next = burst_beats(hburst);
                HTRANS_SEQ:    rem_next = (rem != '0) ? rem - 1'b1 : '0;
                HTRANS_BUSY:   rem_next = rem;
                default:       rem_next = '0;
            endcase
        end
    end

    // Lock outranks burst: a locked owner keeps the bus even between bursts.
    always_comb begin
        state = ARB_OPEN;
        if (hlock[grant_sel])      state = ARB_LOCK;
        else if (rem_next != '0)   state = ARB_BURST;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_q   <= NMST'(1) << DEF_MST;
            hmaster   <= '0;
            hmastlock <= 1'b0;
            rem       <= '0;
        end else begin
            rem <= rem_next;
            if (hready) begin
                if (state == ARB_OPEN) grant_q <= pick_oh;
                hmaster   <= 4'(grant_sel);
                hmastlock <= hlock[grant_sel];
            end
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: reset, pick order, burst hold, wait states,
// lock, early termination, malformed prio fields and reset mid-burst.
module tb_ahb_arbiter;

    logic        clk;
    logic        rst;
    logic [4:0]  hbusreq;
    logic [4:0]  hlock;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic        hready;
    logic [24:0] prio;
    logic [15:0] hgrantx;
    logic [3:0]  hmaster;
    logic        hmastlock;

    int nvec = 0;
    int nbad = 0;

    localparam logic [24:0] P0 = 25'b00001_00010_00100_01000_10000;
    localparam logic [24:0] P_BAD = 25'b00001_00010_00100_11000_00000;

    ahb_arbiter #(.NMST(5), .DEF_MST(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .hbusreq   (hbusreq),
        .hlock     (hlock),
        .htrans    (htrans),
        .hburst    (hburst),
        .hready    (hready),
        .prio      (prio),
        .hgrantx   (hgrantx),
        .hmaster   (hmaster),
        .hmastlock (hmastlock)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; hbusreq = '0; hlock = '0; htrans = 2'd0; hburst = 3'd0;
        hready = 1'b1; prio = P0;
        #1 rst = 1'b1;
        #2;
        chk("rst_grant", 32'(hgrantx), 32'h0001);
        chk("rst_master", 32'(hmaster), 0);
        chk("rst_mlock", 32'(hmastlock), 0);
        step();
        rst = 1'b0;
        step();
        chk("idle_grant", 32'(hgrantx), 32'h0001);
        chk("idle_master", 32'(hmaster), 0);
        chk("idle_mlock", 32'(hmastlock), 0);

        // priority pick: masters 1 and 2 request, field order favours 2
        hbusreq = 5'b00110;
        step();
        chk("pick_grant", 32'(hgrantx), 32'h0004);
        chk("pick_master_lag", 32'(hmaster), 0);
        step();
        chk("pick_master", 32'(hmaster), 2);

        // INCR4 from master 2, master 1 keeps requesting
        htrans = 2'd2; hburst = 3'd3;
        step();
        chk("i4_nonseq_grant", 32'(hgrantx), 32'h0004);
        chk("i4_nonseq_rem", 32'(dut.rem), 3);
        htrans = 2'd3; hbusreq = 5'b00010;
        step();
        chk("i4_seq1_grant", 32'(hgrantx), 32'h0004);
        chk("i4_seq1_rem", 32'(dut.rem), 2);
        step();
        chk("i4_seq2_grant", 32'(hgrantx), 32'h0004);
        chk("i4_seq2_rem", 32'(dut.rem), 1);

        // three wait states before the last beat
        hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ws_grant", 32'(hgrantx), 32'h0004);
            chk("ws_master", 32'(hmaster), 2);
            chk("ws_rem", 32'(dut.rem), 1);
        end
        hready = 1'b1;
        step();
        chk("i4_last_grant", 32'(hgrantx), 32'h0002);
        chk("i4_last_rem", 32'(dut.rem), 0);
        chk("i4_last_master", 32'(hmaster), 2);
        htrans = 2'd0;
        step();
        chk("i4_new_master", 32'(hmaster), 1);

        // lock: master 3 locked, master 4 (higher) requests
        hbusreq = 5'b01000; hlock = 5'b01000;
        step();
        chk("lk_grant", 32'(hgrantx), 32'h0008);
        hbusreq = 5'b11000;
        step();
        chk("lk_hold_grant", 32'(hgrantx), 32'h0008);
        chk("lk_master", 32'(hmaster), 3);
        chk("lk_mlock", 32'(hmastlock), 1);
        step();
        chk("lk_hold2_grant", 32'(hgrantx), 32'h0008);
        chk("lk_hold2_mlock", 32'(hmastlock), 1);
        hlock = 5'b00000;
        step();
        chk("lk_rel_grant", 32'(hgrantx), 32'h0010);
        chk("lk_rel_mlock", 32'(hmastlock), 0);

        // INCR8 from master 4, terminated with IDLE after two beats
        hbusreq = 5'b10010; htrans = 2'd2; hburst = 3'd5;
        step();
        chk("i8_rem7", 32'(dut.rem), 7);
        chk("i8_master", 32'(hmaster), 4);
        htrans = 2'd3;
        step();
        chk("i8_rem6", 32'(dut.rem), 6);
        chk("i8_hold_grant", 32'(hgrantx), 32'h0010);
        htrans = 2'd0; hbusreq = 5'b00010;
        step();
        chk("i8_term_rem", 32'(dut.rem), 0);
        chk("i8_term_grant", 32'(hgrantx), 32'h0002);

        // zero and multi-hot fields skipped, field 2 (master 2) wins
        prio = P_BAD; hbusreq = 5'b11110;
        step();
        chk("bad_fld_grant", 32'(hgrantx), 32'h0004);
        hbusreq = 5'b00000;
        step();
        chk("default_grant", 32'(hgrantx), 32'h0001);

        // reset in the middle of an INCR16
        prio = P0; hbusreq = 5'b00100;
        step();
        step();
        htrans = 2'd2; hburst = 3'd7;
        step();
        chk("i16_rem", 32'(dut.rem), 15);
        chk("i16_grant", 32'(hgrantx), 32'h0004);
        #2 rst = 1'b1;
        #1;
        chk("mrst_grant", 32'(hgrantx), 32'h0001);
        chk("mrst_master", 32'(hmaster), 0);
        chk("mrst_mlock", 32'(hmastlock), 0);
        chk("mrst_rem", 32'(dut.rem), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
